// File: rtl/regfile_cmd_sequencer_pkg.sv
// Shared definitions for the register-file command sequencer, the control
// unit and the register file: widths, register count, op codes, FSM states.
package regfile_cmd_sequencer_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 4;

    typedef enum logic [1:0] {
        OP_MOV   = 2'b00,
        OP_SWAP  = 2'b01,
        OP_LOADI = 2'b10,
        OP_CLR   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_READ  = 3'd2,
        ST_WR1   = 3'd3,
        ST_WR2   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

    // True when the address selects one of the implemented registers.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
        return (addr < ADDR_W'(NUM_REGS));
    endfunction

    // True for ops that read a source register.
    function automatic logic op_uses_src(input op_e op);
        return (op == OP_MOV) || (op == OP_SWAP);
    endfunction

endpackage

// File: rtl/regfile_cmd_sequencer.sv
// Command-driven initiator for the 4-entry register file. Accepts one
// MOV/SWAP/LOADI/CLR at a time, sequences read/write cycles on the register
// file ports and reports completion (done) or an illegal address (err).
module regfile_cmd_sequencer
    import regfile_cmd_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              done,
    output logic              err,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic [ADDR_W-1:0] rf_rd_addr_a,
    output logic [ADDR_W-1:0] rf_rd_addr_b,
    input  logic [DATA_W-1:0] rf_rd_data_a,
    input  logic [DATA_W-1:0] rf_rd_data_b,
    output logic              rf_register_dis
);

    state_e            state_r, state_nxt_s;
    op_e               op_r;
    logic [ADDR_W-1:0] src_r, dst_r;
    logic [DATA_W-1:0] imm_r;
    logic [DATA_W-1:0] hold_a_r, hold_b_r;
    // Last driven addresses/data, so the ports hold value outside READ/WR.
    logic [ADDR_W-1:0] rd_addr_a_r, rd_addr_b_r, wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;

    logic              cmd_accept_s;
    logic              cmd_legal_s;
    logic [DATA_W-1:0] wr1_data_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s, rd_addr_a_s, rd_addr_b_s;
    logic [DATA_W-1:0] wr_data_s;

    assign cmd_ready       = (state_r == ST_IDLE) && !rst;
    assign cmd_accept_s    = cmd_valid && cmd_ready;
    assign done            = (state_r == ST_DONE);
    assign err             = (state_r == ST_ERR);
    // Gating with rst keeps a reset landing mid-write from corrupting the file.
    assign rf_write        = wr_en_s && !rst;
    assign rf_wr_addr      = wr_addr_s;
    assign rf_wr_data      = wr_data_s;
    assign rf_rd_addr_a    = rd_addr_a_s;
    assign rf_rd_addr_b    = rd_addr_b_s;
    assign rf_register_dis = 1'b0;

    // Next-state and per-state port decode from the state and latched command.
    always_comb begin
        state_nxt_s = state_r;
        wr_en_s     = 1'b0;
        wr_addr_s   = wr_addr_r;
        wr_data_s   = wr_data_r;
        rd_addr_a_s = rd_addr_a_r;
        rd_addr_b_s = rd_addr_b_r;
        cmd_legal_s = addr_legal(dst_r) && (!op_uses_src(op_r) || addr_legal(src_r));

        case (op_r)
            OP_MOV, OP_SWAP: wr1_data_s = hold_a_r;
            OP_LOADI:        wr1_data_s = imm_r;
            OP_CLR:          wr1_data_s = {DATA_W{1'b0}};
            default:         wr1_data_s = {DATA_W{1'b0}};
        endcase

        case (state_r)
            ST_IDLE: begin
                if (cmd_accept_s) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (!cmd_legal_s) begin
                    state_nxt_s = ST_ERR;
                end else if (op_uses_src(op_r)) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_WR1;
                end
            end
            ST_READ: begin
                rd_addr_a_s = src_r;
                rd_addr_b_s = dst_r;
                state_nxt_s = ST_WR1;
            end
            ST_WR1: begin
                wr_en_s   = 1'b1;
                wr_addr_s = dst_r;
                wr_data_s = wr1_data_s;
                if (op_r == OP_SWAP) begin
                    state_nxt_s = ST_WR2;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_WR2: begin
                wr_en_s     = 1'b1;
                wr_addr_s   = src_r;
                wr_data_s   = hold_b_r;
                state_nxt_s = ST_DONE;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            ST_ERR:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, command capture, read-data hold and last-driven port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_MOV;
            src_r       <= {ADDR_W{1'b0}};
            dst_r       <= {ADDR_W{1'b0}};
            imm_r       <= {DATA_W{1'b0}};
            hold_a_r    <= {DATA_W{1'b0}};
            hold_b_r    <= {DATA_W{1'b0}};
            rd_addr_a_r <= {ADDR_W{1'b0}};
            rd_addr_b_r <= {ADDR_W{1'b0}};
            wr_addr_r   <= {ADDR_W{1'b0}};
            wr_data_r   <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (cmd_accept_s) begin
                op_r  <= op_e'(cmd_op);
                src_r <= cmd_src;
                dst_r <= cmd_dst;
                imm_r <= cmd_imm;
            end
            if (state_r == ST_READ) begin
                hold_a_r    <= rf_rd_data_a;
                hold_b_r    <= rf_rd_data_b;
                rd_addr_a_r <= rd_addr_a_s;
                rd_addr_b_r <= rd_addr_b_s;
            end
            if (wr_en_s) begin
                wr_addr_r <= wr_addr_s;
                wr_data_r <= wr_data_s;
            end
        end
    end

endmodule

// File: tb/tb_regfile_cmd_sequencer.sv
// Scoreboard bench for regfile_cmd_sequencer: a behavioural register file is
// attached to the DUT ports, a reference model predicts write events and the
// completion/error response for every accepted command, and a monitor checks
// them as the DUT produces them.
module tb_regfile_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_src, cmd_dst;
    logic [15:0] cmd_imm;
    logic        done, err;
    logic        rf_write;
    logic [2:0]  rf_wr_addr, rf_rd_addr_a, rf_rd_addr_b;
    logic [15:0] rf_wr_data, rf_rd_data_a, rf_rd_data_b;
    logic        rf_register_dis;

    regfile_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .done(done), .err(err),
        .rf_write(rf_write), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
        .rf_register_dis(rf_register_dis)
    );

    always #5 clk = ~clk;

    // Behavioural register file: combinational reads, write on rising edge.
    logic [3:0][15:0] rf_mem = '0;
    assign rf_rd_data_a = (rf_rd_addr_a < 3'd4) ? rf_mem[rf_rd_addr_a[1:0]] : 16'hDEAD;
    assign rf_rd_data_b = (rf_rd_addr_b < 3'd4) ? rf_mem[rf_rd_addr_b[1:0]] : 16'hDEAD;
    always @(posedge clk) begin
        if (rf_write && rf_wr_addr < 3'd4) rf_mem[rf_wr_addr[1:0]] <= rf_wr_data;
    end

    int cyc = 0;
    // Cycle counter; cycle N of a command is cyc == base + N.
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct packed {
        int          cyc;
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_ev_t;

    typedef struct packed {
        logic             is_err;
        int               end_cyc;
        logic [3:0][15:0] regs;   // expected register file after completion
        logic [3:0][15:0] snap;   // register file before the command
    } resp_t;

    wr_ev_t           wr_q[$];
    resp_t            resp_q[$];
    logic [3:0][15:0] model_regs = '0;

    // Reference model: architectural effect and cycle timing of one command.
    task automatic model_cmd(input int base, input logic [1:0] op, input logic [2:0] src,
                             input logic [2:0] dst, input logic [15:0] imm);
        resp_t       r;
        logic [15:0] a, b;
        bit          uses_src;
        r.snap   = model_regs;
        r.is_err = 1'b0;
        uses_src = (op == 2'd0) || (op == 2'd1);
        if (dst >= 3'd4 || (uses_src && src >= 3'd4)) begin
            r.is_err  = 1'b1;
            r.end_cyc = base + 2;
        end else begin
            case (op)
                2'd0: begin
                    a = model_regs[src[1:0]];
                    wr_q.push_back('{base + 3, dst, a});
                    model_regs[dst[1:0]] = a;
                    r.end_cyc = base + 4;
                end
                2'd1: begin
                    a = model_regs[src[1:0]];
                    b = model_regs[dst[1:0]];
                    wr_q.push_back('{base + 3, dst, a});
                    wr_q.push_back('{base + 4, src, b});
                    model_regs[dst[1:0]] = a;
                    model_regs[src[1:0]] = b;
                    r.end_cyc = base + 5;
                end
                2'd2: begin
                    wr_q.push_back('{base + 2, dst, imm});
                    model_regs[dst[1:0]] = imm;
                    r.end_cyc = base + 3;
                end
                default: begin
                    wr_q.push_back('{base + 2, dst, 16'h0000});
                    model_regs[dst[1:0]] = 16'h0000;
                    r.end_cyc = base + 3;
                end
            endcase
        end
        r.regs = model_regs;
        resp_q.push_back(r);
    endtask

    // Monitor: compares writes and responses, detects acceptances, flushes on reset.
    always @(negedge clk) begin
        wr_ev_t w;
        resp_t  r;
        if (rst) begin
            check("write_during_rst", rf_write, 1'b0);
            check("resp_during_rst", {done, err}, 2'b00);
            // Reset here only lands before any write of the command, so the
            // file still holds the pre-command contents.
            if (resp_q.size() > 0) model_regs = resp_q[0].snap;
            resp_q.delete();
            wr_q.delete();
        end else begin
            if (rf_write) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", {rf_wr_addr, rf_wr_data}, 19'h0);
                end else begin
                    w = wr_q.pop_front();
                    check("write_cycle", cyc, w.cyc);
                    check("write_addr_data", {rf_wr_addr, rf_wr_data}, {w.addr, w.data});
                end
            end
            if (done || err) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_resp", {done, err}, 2'b00);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_kind", {done, err}, r.is_err ? 2'b01 : 2'b10);
                    check("resp_cycle", cyc, r.end_cyc);
                    check("regs_at_resp", rf_mem, r.regs);
                end
            end
            if (wr_q.size() > 0 && cyc > wr_q[0].cyc) begin
                w = wr_q.pop_front();
                check("missing_write", {3'd0, 16'h0}, {w.addr, w.data});
            end
            if (resp_q.size() > 0 && cyc > resp_q[0].end_cyc) begin
                r = resp_q.pop_front();
                check("missing_resp", {done, err}, r.is_err ? 2'b01 : 2'b10);
            end
            if (cmd_ready) begin
                check("ready_while_busy", resp_q.size() + wr_q.size(), 0);
                if (cmd_valid) model_cmd(cyc, cmd_op, cmd_src, cmd_dst, cmd_imm);
            end
        end
    end

    task automatic scramble();
        cmd_op  = 2'($urandom_range(0, 3));
        cmd_src = 3'($urandom_range(0, 7));
        cmd_dst = 3'($urandom_range(0, 7));
        cmd_imm = 16'($urandom);
    endtask

    // Present a command until accepted, then withdraw it with garbage fields.
    task automatic issue(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                         input logic [15:0] imm);
        bit got = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) got = 1'b1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        scramble();
        check("accept_timeout", got, 1'b1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 20 && !idle; i++) begin
            @(negedge clk);
            if (cmd_ready) idle = 1'b1;
        end
        check("idle_timeout", idle, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b1;     // must be ignored while in reset
        scramble();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_rst", cmd_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1'b1);
        check("outputs_after_rst",
              {done, err, rf_write, rf_wr_addr, rf_wr_data, rf_rd_addr_a, rf_rd_addr_b, rf_register_dis},
              '0);
        @(posedge clk); #1;

        // LOADI, SWAP with distinct registers
        issue(2'd2, 3'd0, 3'd2, 16'hBEEF); wait_idle();
        issue(2'd2, 3'd0, 3'd0, 16'h1234); wait_idle();
        issue(2'd2, 3'd0, 3'd3, 16'hABCD); wait_idle();
        issue(2'd1, 3'd0, 3'd3, 16'h0000); wait_idle();
        // Self-MOV and self-SWAP leave registers unchanged
        issue(2'd2, 3'd0, 3'd1, 16'h5555); wait_idle();
        issue(2'd0, 3'd1, 3'd1, 16'h0000); wait_idle();
        issue(2'd1, 3'd2, 3'd2, 16'h0000); wait_idle();
        // Illegal source and destination addresses
        issue(2'd0, 3'd5, 3'd0, 16'h0000); wait_idle();
        issue(2'd3, 3'd0, 3'd4, 16'h0000); wait_idle();
        issue(2'd2, 3'd7, 3'd1, 16'h7777); wait_idle();  // LOADI ignores src

        // Reset during WR1 of a SWAP: no write, no response
        issue(2'd1, 3'd1, 3'd2, 16'h0000);
        @(posedge clk);        // enter READ
        @(posedge clk); #1;    // enter WR1
        rst = 1'b1;
        @(negedge clk);
        check("ready_in_mid_rst", cmd_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_mid_rst", cmd_ready, 1'b1);
        @(posedge clk); #1;
        issue(2'd3, 3'd0, 3'd3, 16'hFFFF); wait_idle();

        // Randomized single commands
        repeat (60) begin
            issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 4)),
                  3'($urandom_range(0, 4)), 16'($urandom));
            wait_idle();
        end

        // Continuous valid with fields changing every cycle
        cmd_valid = 1'b1;
        repeat (200) begin
            cmd_op  = 2'($urandom_range(0, 3));
            cmd_src = 3'($urandom_range(0, 4));
            cmd_dst = 3'($urandom_range(0, 4));
            cmd_imm = 16'($urandom);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        wait_idle();

        repeat (3) @(negedge clk);
        check("queues_drained", resp_q.size() + wr_q.size(), 0);
        check("final_regs", rf_mem, model_regs);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
